// File: rtl/hilo_pipe.sv
`default_nettype none
// ============================================================================
// Module   : hilo_pipe
// Purpose  : HI/LO write pipeline (EX/MEM, MEM/WB slots) with MFHI/MFLO forwarding.
// Revision : 1.0 - initial release
// ============================================================================
module hilo_pipe (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_whi_i,
    input  logic        ex_wlo_i,
    input  logic [31:0] ex_hi_i,
    input  logic [31:0] ex_lo_i,
    input  logic [2:0]  stall_i,
    input  logic        flush_i,
    output logic [31:0] fwd_hi_o,
    output logic [31:0] fwd_lo_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        pending_o
);

    logic        r_em_whi, r_em_wlo;
    logic [31:0] r_em_hi,  r_em_lo;
    logic        r_mw_whi, r_mw_wlo;
    logic [31:0] r_mw_hi,  r_mw_lo;
    logic [31:0] r_hi,     r_lo;

    // EX/MEM slot: flush beats stall; a held MEM freezes it, a held EX feeds a bubble
    always_ff @(posedge clk) begin
        if (rst || flush_i || (stall_i[0] && !stall_i[1])) begin
            r_em_whi <= 1'b0;
            r_em_wlo <= 1'b0;
            r_em_hi  <= 32'd0;
            r_em_lo  <= 32'd0;
        end else if (!stall_i[1]) begin
            r_em_whi <= ex_whi_i;
            r_em_wlo <= ex_wlo_i;
            r_em_hi  <= ex_hi_i;
            r_em_lo  <= ex_lo_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i || (stall_i[1] && !stall_i[2])) begin
            r_mw_whi <= 1'b0;
            r_mw_wlo <= 1'b0;
            r_mw_hi  <= 32'd0;
            r_mw_lo  <= 32'd0;
        end else if (!stall_i[2]) begin
            r_mw_whi <= r_em_whi;
            r_mw_wlo <= r_em_wlo;
            r_mw_hi  <= r_em_hi;
            r_mw_lo  <= r_em_lo;
        end
    end

    // Commit is not gated by flush: the MEM/WB write is older than the faulting instruction
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else begin
            if (r_mw_whi && !stall_i[2]) r_hi <= r_mw_hi;
            if (r_mw_wlo && !stall_i[2]) r_lo <= r_mw_lo;
        end
    end

    logic [31:0] w_fwd_hi, w_fwd_lo;

    always_comb begin
        w_fwd_hi = r_hi;
        if (r_em_whi)      w_fwd_hi = r_em_hi;
        else if (r_mw_whi) w_fwd_hi = r_mw_hi;
        w_fwd_lo = r_lo;
        if (r_em_wlo)      w_fwd_lo = r_em_lo;
        else if (r_mw_wlo) w_fwd_lo = r_mw_lo;
    end

    assign fwd_hi_o  = w_fwd_hi;
    assign fwd_lo_o  = w_fwd_lo;
    assign hi_o      = r_hi;
    assign lo_o      = r_lo;
    assign pending_o = r_em_whi | r_em_wlo | r_mw_whi | r_mw_wlo;

endmodule
`default_nettype wire

// File: tb/tb_hilo_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_hilo_pipe
// Purpose  : Scoreboard bench for hilo_pipe using directed, hand-computed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hilo_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_whi_i, ex_wlo_i;
    logic [31:0] ex_hi_i, ex_lo_i;
    logic [2:0]  stall_i;
    logic        flush_i;
    logic [31:0] fwd_hi_o, fwd_lo_o, hi_o, lo_o;
    logic        pending_o;

    hilo_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .ex_whi_i  (ex_whi_i),
        .ex_wlo_i  (ex_wlo_i),
        .ex_hi_i   (ex_hi_i),
        .ex_lo_i   (ex_lo_i),
        .stall_i   (stall_i),
        .flush_i   (flush_i),
        .fwd_hi_o  (fwd_hi_o),
        .fwd_lo_o  (fwd_lo_o),
        .hi_o      (hi_o),
        .lo_o      (lo_o),
        .pending_o (pending_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [31:0] fhi, flo, hi, lo;
        logic        pend;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   done    = 1'b0;

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
        end
    endtask

    // Monitor: one expectation per edge, sampled 1 time unit after it
    initial begin
        exp_t e;
        while (!done) begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk(e.nm, "fwd_hi", fwd_hi_o, e.fhi);
                chk(e.nm, "fwd_lo", fwd_lo_o, e.flo);
                chk(e.nm, "hi",     hi_o,     e.hi);
                chk(e.nm, "lo",     lo_o,     e.lo);
                chk(e.nm, "pend",   {31'd0, pending_o}, {31'd0, e.pend});
            end
        end
    end

    task automatic step(input string nm, input logic r, input logic whi, input logic wlo,
                        input logic [31:0] h, input logic [31:0] l, input logic [2:0] st,
                        input logic fl, input logic [31:0] efhi, input logic [31:0] eflo,
                        input logic [31:0] ehi, input logic [31:0] elo, input logic ep);
        exp_t e;
        rst = r; ex_whi_i = whi; ex_wlo_i = wlo; ex_hi_i = h; ex_lo_i = l;
        stall_i = st; flush_i = fl;
        e.nm = nm; e.fhi = efhi; e.flo = eflo; e.hi = ehi; e.lo = elo; e.pend = ep;
        q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input string nm, input logic [31:0] efhi, input logic [31:0] eflo,
                        input logic [31:0] ehi, input logic [31:0] elo, input logic ep);
        step(nm, 0, 0, 0, 32'd0, 32'd0, 3'b000, 0, efhi, eflo, ehi, elo, ep);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset while a write is presented
        step("reset", 1, 1, 1, 32'hDEAD0000, 32'hBEEF0000, 3'b000, 0, 0, 0, 0, 0, 0);
        idle("rst_idle", 0, 0, 0, 0, 0);

        // DIVU result, no stalls
        step("divu_e1", 0, 1, 1, 32'h1, 32'h4, 3'b000, 0, 32'h1, 32'h4, 0, 0, 1);
        idle("divu_e2", 32'h1, 32'h4, 0, 0, 1);
        idle("divu_e3", 32'h1, 32'h4, 32'h1, 32'h4, 0);

        step("reset2", 1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0);

        // back-to-back MTHI
        step("mthi_a", 0, 1, 0, 32'hAAAA0000, 32'h0, 3'b000, 0, 32'hAAAA0000, 0, 0, 0, 1);
        step("mthi_b", 0, 1, 0, 32'h5555FFFF, 32'h0, 3'b000, 0, 32'h5555FFFF, 0, 0, 0, 1);
        idle("mthi_c", 32'h5555FFFF, 0, 32'hAAAA0000, 0, 1);
        idle("mthi_d", 32'h5555FFFF, 0, 32'h5555FFFF, 0, 0);

        // MTLO killed by flush in EX/MEM
        step("mtlo_in", 0, 0, 1, 32'h0, 32'h12345678, 3'b000, 0, 32'h5555FFFF, 32'h12345678, 32'h5555FFFF, 0, 1);
        step("flush_em", 0, 0, 0, 0, 0, 3'b000, 1, 32'h5555FFFF, 0, 32'h5555FFFF, 0, 0);
        idle("flush_after", 32'h5555FFFF, 0, 32'h5555FFFF, 0, 0);

        // flush beats stall but MEM/WB write still commits
        step("mtlo11", 0, 0, 1, 32'h0, 32'h11, 3'b000, 0, 32'h5555FFFF, 32'h11, 32'h5555FFFF, 0, 1);
        idle("mtlo11_mw", 32'h5555FFFF, 32'h11, 32'h5555FFFF, 0, 1);
        step("flush_mw", 0, 0, 0, 0, 0, 3'b011, 1, 32'h5555FFFF, 32'h11, 32'h5555FFFF, 32'h11, 0);

        // WB stall holds commit
        step("mthi_c1", 0, 1, 0, 32'hCAFE0001, 0, 3'b000, 0, 32'hCAFE0001, 32'h11, 32'h5555FFFF, 32'h11, 1);
        idle("mthi_c1_mw", 32'hCAFE0001, 32'h11, 32'h5555FFFF, 32'h11, 1);
        step("wb_stall1", 0, 0, 0, 0, 0, 3'b110, 0, 32'hCAFE0001, 32'h11, 32'h5555FFFF, 32'h11, 1);
        step("wb_stall2", 0, 1, 1, 32'h0BAD, 32'h0BAD, 3'b110, 0, 32'hCAFE0001, 32'h11, 32'h5555FFFF, 32'h11, 1);
        idle("wb_release", 32'hCAFE0001, 32'h11, 32'hCAFE0001, 32'h11, 0);

        // divider busy: EX stalled, EX/MEM must only see bubbles
        for (int i = 0; i < 33; i++)
            step("div_busy", 0, 1, 1, 32'hDEAD, 32'hBEEF, 3'b001, 0, 32'hCAFE0001, 32'h11, 32'hCAFE0001, 32'h11, 0);
        step("div_res", 0, 1, 1, 32'h3, 32'h7, 3'b000, 0, 32'h3, 32'h7, 32'hCAFE0001, 32'h11, 1);
        idle("div_mw", 32'h3, 32'h7, 32'hCAFE0001, 32'h11, 1);
        idle("div_commit", 32'h3, 32'h7, 32'h3, 32'h7, 0);
        idle("div_quiet", 32'h3, 32'h7, 32'h3, 32'h7, 0);

        // HI and LO forwarded from different slots
        step("indep_hi", 0, 1, 0, 32'h100, 32'h999, 3'b000, 0, 32'h100, 32'h7, 32'h3, 32'h7, 1);
        step("indep_lo", 0, 0, 1, 32'h888, 32'h200, 3'b000, 0, 32'h100, 32'h200, 32'h3, 32'h7, 1);

        // reset with both slots holding writes
        step("rst_inflt", 1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0);
        idle("rst_post1", 0, 0, 0, 0, 0);
        idle("rst_post2", 0, 0, 0, 0, 0);

        @(posedge clk);
        #2;
        done = 1'b1;
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d unchecked expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
